// File: rtl/char_grid_pkg.sv
// Shared types and constants for the character-cell grid buffer.
package char_grid_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } grid_state_t;

  localparam logic [7:0] DEFAULT_CLEAR_CHAR = 8'h20;

  // Address width for a grid of n cells; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/char_grid_ram.sv
// Simple dual-port cell store: one write port, one registered read-first read port, no reset.
module char_grid_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments, so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end

endmodule

// File: rtl/char_grid_buffer.sv
// COLS x ROWS character grid with clear sequencer, one-entry pending write and registered read port.
// Optional per-row dirty tracking is enabled by defining CHAR_GRID_DIRTY_EN.
module char_grid_buffer
  import char_grid_pkg::*;
#(
  parameter int         XW         = 4,
  parameter int         YW         = 4,
  parameter int         COLS       = 16,
  parameter int         ROWS       = 16,
  parameter logic [7:0] CLEAR_CHAR = DEFAULT_CLEAR_CHAR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_ch,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [7:0]    ch,
  input  logic          clear,
  output logic          busy,
  output logic          overrun,
  input  logic          rd_req,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rd_valid,
  output logic [7:0]    rd_data
`ifdef CHAR_GRID_DIRTY_EN
  ,
  output logic [ROWS-1:0] dirty_rows,
  input  logic            dirty_clr,
  input  logic [YW-1:0]   dirty_clr_row
`endif
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = clog2(CELLS);

  grid_state_t   state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg, clr_cnt_next;
  logic          pend_valid_reg, pend_valid_next;
  logic [AW-1:0] pend_addr_reg, pend_addr_next;
  logic [7:0]    pend_ch_reg, pend_ch_next;
  logic          overrun_reg, overrun_next;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic          set_ok;
  logic [AW-1:0] set_addr;
  logic          rd_in_range;
  logic [AW-1:0] rd_addr;

  logic          rd_valid_reg;
  logic          rd_oob_reg;
  logic          rd_seen_reg;
  logic [7:0]    ram_q;

  assign set_ok   = set_ch && (int'(x) < COLS) && (int'(y) < ROWS);
  assign set_addr = AW'(int'(y) * COLS + int'(x));

  assign rd_in_range = (int'(rd_x) < COLS) && (int'(rd_y) < ROWS);
  assign rd_addr     = AW'(int'(rd_y) * COLS + int'(rd_x));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= CLEAR;
      clr_cnt_reg    <= '0;
      pend_valid_reg <= 1'b0;
      pend_addr_reg  <= '0;
      pend_ch_reg    <= 8'h00;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_cnt_reg    <= clr_cnt_next;
      pend_valid_reg <= pend_valid_next;
      pend_addr_reg  <= pend_addr_next;
      pend_ch_reg    <= pend_ch_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    clr_cnt_next    = clr_cnt_reg;
    pend_valid_next = pend_valid_reg;
    pend_addr_next  = pend_addr_reg;
    pend_ch_next    = pend_ch_reg;
    overrun_next    = overrun_reg;
    wr_en           = 1'b0;
    wr_addr         = set_addr;
    wr_data         = ch;

    case (state_reg)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_reg;
        wr_data = CLEAR_CHAR;
        if (clr_cnt_reg == AW'(CELLS - 1)) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
        // Writes arriving mid-clear are parked; a second one replaces the first.
        if (set_ok) begin
          if (pend_valid_reg) overrun_next = 1'b1;
          pend_valid_next = 1'b1;
          pend_addr_next  = set_addr;
          pend_ch_next    = ch;
        end
      end

      default: begin
        if (clear) state_next = CLEAR;
        if (pend_valid_reg) begin
          // Drain the parked write first; a simultaneous new write takes its slot.
          wr_en           = 1'b1;
          wr_addr         = pend_addr_reg;
          wr_data         = pend_ch_reg;
          pend_valid_next = set_ok;
          if (set_ok) begin
            pend_addr_next = set_addr;
            pend_ch_next   = ch;
          end
        end else if (set_ok) begin
          wr_en = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_oob_reg   <= 1'b0;
      rd_seen_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= rd_req;
      if (rd_req) begin
        rd_oob_reg  <= !rd_in_range;
        rd_seen_reg <= 1'b1;
      end
    end
  end

  char_grid_ram #(
    .DW    (8),
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk (clk),
    .we  (wr_en),
    .wa  (wr_addr),
    .wd  (wr_data),
    .re  (rd_req && rd_in_range),
    .ra  (rd_addr),
    .q   (ram_q)
  );

  // The RAM output register has no reset, so report zero until the first read completes.
  assign rd_data  = !rd_seen_reg ? 8'h00 : (rd_oob_reg ? CLEAR_CHAR : ram_q);
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg == CLEAR);
  assign overrun  = overrun_reg;

`ifdef CHAR_GRID_DIRTY_EN
  logic [YW-1:0]   pend_row_reg;
  logic [YW-1:0]   wr_row;
  logic [ROWS-1:0] dirty_reg;

  // Every accepted write either goes straight to RAM with the buffer empty or lands in
  // the buffer, so tracking the row of the latest accepted write is sufficient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_row_reg <= '0;
    else if (set_ok) pend_row_reg <= y;
  end

  assign wr_row = (state_reg == IDLE && pend_valid_reg) ? pend_row_reg : y;

  genvar gi;
  for (gi = 0; gi < ROWS; gi++) begin : g_dirty
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dirty_reg[gi] <= 1'b1;
      end else if (state_reg == CLEAR || (wr_en && int'(wr_row) == gi)) begin
        dirty_reg[gi] <= 1'b1;
      end else if (dirty_clr && int'(dirty_clr_row) == gi) begin
        dirty_reg[gi] <= 1'b0;
      end
    end
  end

  assign dirty_rows = dirty_reg;
`endif

endmodule

// File: tb/tb_char_grid_buffer.sv
// Self-checking bench for char_grid_buffer: directed steps plus randomized writes against a grid model.
module tb_char_grid_buffer;

  localparam int         COLS  = 16;
  localparam int         ROWS  = 16;
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] CC    = 8'h20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       set_ch = 1'b0;
  logic [3:0] x = '0, y = '0;
  logic [7:0] ch = '0;
  logic       clear = 1'b0;
  logic       busy, overrun;
  logic       rd_req = 1'b0;
  logic [3:0] rd_x = '0, rd_y = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
`ifdef CHAR_GRID_DIRTY_EN
  logic [ROWS-1:0] dirty_rows;
  logic            dirty_clr = 1'b0;
  logic [3:0]      dirty_clr_row = '0;
`endif

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] model [CELLS];
  logic       exp_overrun;

  char_grid_buffer dut (
    .clk      (clk),
    .reset    (reset),
    .set_ch   (set_ch),
    .x        (x),
    .y        (y),
    .ch       (ch),
    .clear    (clear),
    .busy     (busy),
    .overrun  (overrun),
    .rd_req   (rd_req),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
`ifdef CHAR_GRID_DIRTY_EN
    ,
    .dirty_rows    (dirty_rows),
    .dirty_clr     (dirty_clr),
    .dirty_clr_row (dirty_clr_row)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_model();
    for (int i = 0; i < CELLS; i++) model[i] = CC;
  endtask

  task automatic wait_busy_low(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check({tag, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic drive_write(input int cx, input int cy, input logic [7:0] c);
    set_ch = 1'b1;
    x = 4'(cx);
    y = 4'(cy);
    ch = c;
    tick();
    set_ch = 1'b0;
  endtask

  task automatic start_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_cell(input string tag, input int cx, input int cy);
    rd_req = 1'b1;
    rd_x = 4'(cx);
    rd_y = 4'(cy);
    tick();
    rd_req = 1'b0;
    check(tag, {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, model[cy * COLS + cx]});
  endtask

  // Back-to-back reads of the whole grid, one request per cycle.
  task automatic sweep(input string tag);
    for (int i = 0; i < CELLS; i++) begin
      rd_req = 1'b1;
      rd_x = 4'(i % COLS);
      rd_y = 4'(i / COLS);
      tick();
      check(tag, {15'd0, 8'(i), rd_valid, rd_data}, {15'd0, 8'(i), 1'b1, model[i]});
    end
    rd_req = 1'b0;
  endtask

  initial begin
    int n;
    int nw;
    int px, py;
    logic [7:0] pc;

    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'h00);
`ifdef CHAR_GRID_DIRTY_EN
    check("reset_dirty", 32'(dirty_rows), 32'hFFFF);
`endif

    // Auto-clear after reset release lasts one cycle per cell.
    reset = 1'b0;
    wait_busy_low("auto_clear", n);
    check("auto_clear_len", n, CELLS);
    fill_model();
    exp_overrun = 1'b0;
    check_cell("cell_0_0", 0, 0);
    check_cell("cell_15_15", 15, 15);
    check_cell("cell_7_3", 7, 3);

    // Write with a same-cycle read of that cell: old data comes back.
    set_ch = 1'b1; x = 4'd3; y = 4'd2; ch = 8'h41;
    rd_req = 1'b1; rd_x = 4'd3; rd_y = 4'd2;
    tick();
    set_ch = 1'b0; rd_req = 1'b0;
    check("read_first", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, CC});
    model[2 * COLS + 3] = 8'h41;
    check_cell("write_then_read", 3, 2);
    tick();
    check("rd_valid_drop", 32'(rd_valid), 32'd0);
    check("rd_data_hold", 32'(rd_data), 32'h41);

`ifdef CHAR_GRID_DIRTY_EN
    for (int r = 0; r < ROWS; r++) begin
      dirty_clr = 1'b1;
      dirty_clr_row = 4'(r);
      tick();
    end
    dirty_clr = 1'b0;
    check("dirty_all_clr", 32'(dirty_rows), 32'h0000);
    drive_write(4, 5, 8'h30);
    model[5 * COLS + 4] = 8'h30;
    check("dirty_row5", 32'(dirty_rows), 32'h0020);
    dirty_clr = 1'b1; dirty_clr_row = 4'd5;
    drive_write(2, 5, 8'h31);
    dirty_clr = 1'b0;
    model[5 * COLS + 2] = 8'h31;
    check("dirty_set_wins", 32'(dirty_rows), 32'h0020);
    dirty_clr = 1'b1; dirty_clr_row = 4'd5;
    tick();
    dirty_clr = 1'b0;
    check("dirty_clr_row5", 32'(dirty_rows), 32'h0000);
`endif

    // Clear with one write parked mid-sequence.
    start_clear();
    check("clear_busy", 32'(busy), 32'd1);
    repeat (9) tick();
    drive_write(1, 1, 8'h42);
    wait_busy_low("clear1", n);
    check("clear1_len", 10 + n, CELLS);
    fill_model();
    model[1 * COLS + 1] = 8'h42;
    tick();
    sweep("clear1_grid");
    check("clear1_overrun", 32'(overrun), 32'd0);

    // Two parked writes to one cell, plus a clear pulse that must not restart the sequence.
    start_clear();
    repeat (4) tick();
    clear = 1'b1;
    drive_write(0, 0, 8'h58);
    clear = 1'b0;
    repeat (3) tick();
    drive_write(0, 0, 8'h59);
    wait_busy_low("clear2", n);
    check("clear2_len", 9 + n, CELLS);
    fill_model();
    model[0] = 8'h59;
    exp_overrun = 1'b1;
    tick();
    check_cell("pend_replace", 0, 0);
    check("overrun_set", 32'(overrun), 32'd1);

    // Randomized rounds: sparse writes during the clear, then a back-to-back burst at its end.
    for (int round = 0; round < 3; round++) begin
      start_clear();
      nw = 0;
      px = 0; py = 0; pc = 8'h00;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(19) == 0) begin
          px = int'($urandom_range(COLS - 1));
          py = int'($urandom_range(ROWS - 1));
          pc = 8'($urandom);
          nw++;
          drive_write(px, py, pc);
        end else begin
          tick();
        end
      end
      wait_busy_low("rand_clear", n);
      check("rand_clear_len", 200 + n, CELLS);
      fill_model();
      if (nw > 0) model[py * COLS + px] = pc;
      if (nw > 1) exp_overrun = 1'b1;
      for (int k = 0; k < 8; k++) begin
        px = int'($urandom_range(COLS - 1));
        py = int'($urandom_range(ROWS - 1));
        pc = 8'($urandom);
        drive_write(px, py, pc);
        model[py * COLS + px] = pc;
      end
      tick();
      sweep("rand_grid");
      check("rand_overrun", 32'(overrun), 32'(exp_overrun));
    end

    // Reset in the middle of a clear restarts it from address 0.
    drive_write(9, 9, 8'h77);
    start_clear();
    repeat (100) tick();
    reset = 1'b1;
    tick();
    check("midreset_busy", 32'(busy), 32'd1);
    check("midreset_overrun", 32'(overrun), 32'd0);
    check("midreset_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    wait_busy_low("midreset", n);
    check("midreset_len", n, CELLS);
    fill_model();
    sweep("midreset_grid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
